wb_scoreboard_arbiter: RTL and testbench
========================================

Name: wb_scoreboard_arbiter

Overview:
- Issue-side hazard controller for the 4-slot VLIW core.
- Tracks destination registers of long-latency ops (load, FPU, div) in a 128-entry busy scoreboard and raises a stall for issue bundles that hit a busy register.
- Arbitrates completions from N long-latency units onto the single shared late register-file write port with round-robin fairness.
- Sits beside decode/writeback; its stall output ORs into the pipeline stall.

Parameters:
- N_REQ, 2, number of long-latency completion requesters (legal 1..4).
- DATA_W, 32, register write data width.
- REG_W, 7, register address width (128 registers; address 0 = no write, never busy).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ext_stall  in  1  downstream pipeline stall; no issue accepted while high.
- slot_valid  in  4  per-slot instruction valid in issuing bundle.
- slot_long  in  4  per-slot long-latency op flag.
- slot_rd  in  4*REG_W  per-slot destination register.
- slot_rs1  in  4*REG_W  per-slot source 1.
- slot_rs2  in  4*REG_W  per-slot source 2.
- hazard_stall  out  1  bundle must not issue this cycle.
- issue_ok  out  1  slot_valid!=0 & ~hazard_stall & ~ext_stall.
- cpl_req  in  N_REQ  completion request per unit; held until granted.
- cpl_rd  in  N_REQ*REG_W  completion destination.
- cpl_data  in  N_REQ*DATA_W  completion data.
- cpl_gnt  out  N_REQ  one-hot grant (combinational, same cycle as req).
- late_we  out  1  shared write-port enable (registered).
- late_rd  out  REG_W  shared write-port address (registered).
- late_data  out  DATA_W  shared write-port data (registered).
- busy_cnt  out  8  number of busy registers.

Behaviour:
- Reset (rst low, async): all busy bits 0, RR pointer 0, late_we 0, late_rd 0, late_data 0, busy_cnt 0. Combinational outputs follow from that state: hazard_stall 0, cpl_gnt 0.
- Hazard: for each valid slot, a hit occurs if rs1, rs2 or rd (WAW) is nonzero and busy. hazard_stall = OR of the per-slot hits. Comparison uses registered busy bits only; no same-cycle bypass.
- Intra-bundle: two valid long slots with the same nonzero rd -> hazard_stall until resolved. Decoder must not emit such bundles; the block stalls forever, and the bench checks the stall.
- Set: on issue_ok, for each valid long slot with rd!=0, the busy bit for rd is set at the clock edge.
- Arbitration: round-robin among asserted cpl_req, starting at index ptr.
  - At most one grant per cycle.
  - On grant of unit i: ptr <= (i+1) mod N_REQ; late_we <= 1; late_rd <= cpl_rd[i]; late_data <= cpl_data[i].
  - With no grant: late_we <= 0 and late_rd/data hold their values.
  - Unit drops req the cycle after its grant.
- Clear: the busy bit for late_rd is cleared at the edge ending the cycle where late_we=1.
  - Grant -> write-port cycle -> unstall: the dependent bundle issues earliest 2 cycles after the grant, after the regfile write has completed.
- Set/clear of the same register at the same edge: the clear applies first, then the set, so the bit ends set. This cannot arise legally, because an issue targeting a busy rd stalls.
- Completion with cpl_rd=0 is granted and written; it clears nothing.
- Completion to a non-busy register is granted normally; the clear is a no-op.
- busy_cnt equals popcount of busy bits; max 127.
- ext_stall high blocks sets only; arbitration and clears continue.

Test Plan:
- Reset: drive rst low mid-run with 5 busy regs -> busy_cnt=0, late_we=0, hazard_stall=0 immediately (asynchronous).
- Long load to r10 issues at t0; the next bundle reads rs1=r10 -> hazard_stall=1. Unit 0 requests at t5 -> cpl_gnt=01 at t5, late_we=1/late_rd=10 at t6, hazard_stall=0 and issue_ok=1 at t7.
- WAW: r20 busy; a bundle with slot2 rd=20 (non-long) -> stall until r20 clears; a slot with rd=0 and rs=0 never stalls.
- Round-robin: both units request continuously for 4 cycles with ptr=0 -> grants 01,10,01,10. Only unit 1 requesting -> grant 10 every cycle.
- Bundle with 4 long slots rd=1,2,3,4 issued under ext_stall=1 -> no bits set. Same bundle with ext_stall=0 -> busy_cnt=4 next cycle.
- Simultaneous events: a long op to r5 issues while a completion for r7 (busy) writes -> r5 set and r7 cleared at the same edge; busy_cnt is unchanged.

Source files
------------

// File: rtl/wb_scoreboard_arbiter_if.sv
// Issue-bundle and completion bus between decode/writeback and the hazard controller.
// The pipeline side uses the master modport; the scoreboard/arbiter uses slave.
interface wb_scoreboard_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 7
);
    // Issue bundle (4 VLIW slots) and resulting stall/issue decision
    logic                    ext_stall;
    logic [3:0]              slot_valid;
    logic [3:0]              slot_long;
    logic [4*REG_W-1:0]      slot_rd;
    logic [4*REG_W-1:0]      slot_rs1;
    logic [4*REG_W-1:0]      slot_rs2;
    logic                    hazard_stall;
    logic                    issue_ok;

    // Long-latency completions and the shared late write port
    logic [N_REQ-1:0]        cpl_req;
    logic [N_REQ*REG_W-1:0]  cpl_rd;
    logic [N_REQ*DATA_W-1:0] cpl_data;
    logic [N_REQ-1:0]        cpl_gnt;
    logic                    late_we;
    logic [REG_W-1:0]        late_rd;
    logic [DATA_W-1:0]       late_data;
    logic [7:0]              busy_cnt;

    modport master (
        output ext_stall, slot_valid, slot_long, slot_rd, slot_rs1, slot_rs2,
        output cpl_req, cpl_rd, cpl_data,
        input  hazard_stall, issue_ok, cpl_gnt, late_we, late_rd, late_data, busy_cnt
    );

    modport slave (
        input  ext_stall, slot_valid, slot_long, slot_rd, slot_rs1, slot_rs2,
        input  cpl_req, cpl_rd, cpl_data,
        output hazard_stall, issue_ok, cpl_gnt, late_we, late_rd, late_data, busy_cnt
    );
endinterface

// File: rtl/wb_scoreboard_arbiter.sv
// Issue-side hazard controller: busy-register scoreboard for long-latency ops
// plus a round-robin arbiter onto the single late register-file write port.
module wb_scoreboard_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 7
) (
    input logic                    clk,
    input logic                    rst,
    wb_scoreboard_arbiter_if.slave bus
);
    localparam int N_REG = 1 << REG_W;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REG-1:0]  busy;
    logic [N_REG-1:0]  busy_nxt;
    logic [PTR_W-1:0]  ptr;
    logic              hazard;
    logic              issue;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    int unsigned       rr_idx;
    logic              late_we;
    logic [REG_W-1:0]  late_rd;
    logic [DATA_W-1:0] late_data;

    function automatic logic [REG_W-1:0] field(input logic [4*REG_W-1:0] v, input int s);
        return v[s*REG_W +: REG_W];
    endfunction

    // Per-slot RAW/WAW hit against registered busy bits, plus duplicate long rd in one bundle
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        hazard = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (bus.slot_valid[s]) begin
                if (field(bus.slot_rs1, s) != '0 && busy[field(bus.slot_rs1, s)]) hazard = 1'b1;
                if (field(bus.slot_rs2, s) != '0 && busy[field(bus.slot_rs2, s)]) hazard = 1'b1;
                if (field(bus.slot_rd, s)  != '0 && busy[field(bus.slot_rd, s)])  hazard = 1'b1;
            end
            for (int t = s + 1; t < 4; t++) begin
                if (bus.slot_valid[s] && bus.slot_long[s] && bus.slot_valid[t] && bus.slot_long[t] &&
                    field(bus.slot_rd, s) != '0 && field(bus.slot_rd, s) == field(bus.slot_rd, t))
                    hazard = 1'b1;
            end
        end
    end

    assign issue            = (|bus.slot_valid) & ~hazard & ~bus.ext_stall;
    assign bus.hazard_stall = hazard;
    assign bus.issue_ok     = issue;

    // Round-robin search over requesters starting at ptr; first hit wins
    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        bus.cpl_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = (int'(ptr) + k) % N_REQ;
            if (!grant_any && bus.cpl_req[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(rr_idx);
            end
        end
        if (grant_any) bus.cpl_gnt = N_REQ'(1) << grant_idx;
    end

    // Next busy vector: clear for the write-port cycle first, then set for issued long ops
    always_comb begin
        busy_nxt = busy;
        if (late_we) busy_nxt[late_rd] = 1'b0;
        if (issue) begin
            for (int s = 0; s < 4; s++) begin
                if (bus.slot_valid[s] && bus.slot_long[s])
                    busy_nxt[field(bus.slot_rd, s)] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;   // r0 is the "no write" address and is never busy
    end

    // Scoreboard, round-robin pointer and registered late write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the busy array is plain flops, not RAM, so it is reset wholesale;
            // a stale busy bit after reset would stall issue forever.
            busy      <= '0;
            ptr       <= '0;
            late_we   <= 1'b0;
            late_rd   <= '0;
            late_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every update here sees pre-edge values.
            busy    <= busy_nxt;
            late_we <= grant_any;
            if (grant_any) begin
                ptr       <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                late_rd   <= bus.cpl_rd[int'(grant_idx)*REG_W +: REG_W];
                late_data <= bus.cpl_data[int'(grant_idx)*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.late_we   = late_we;
    assign bus.late_rd   = late_rd;
    assign bus.late_data = late_data;
    assign bus.busy_cnt  = 8'($countones(busy));

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized bundles/completions compared every cycle against a behavioural model.
module tb_wb_scoreboard_arbiter;
    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_scoreboard_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    wb_scoreboard_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit               m_busy [128];
    int               m_ptr;
    bit               m_we;
    int               m_rd;
    logic [31:0]      m_data;
    logic [N_REQ-1:0] m_last_gnt;

    function automatic int fld(input logic [4*REG_W-1:0] v, input int s);
        return int'(v[s*REG_W +: REG_W]);
    endfunction

    task automatic model_reset();
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        m_ptr = 0; m_we = 1'b0; m_rd = 0; m_data = '0; m_last_gnt = '0;
    endtask

    // A bundle stalls if any register it touches is busy, or two long slots share a destination
    function automatic bit model_hazard();
        int need[$];
        int long_dst[int];
        for (int s = 0; s < 4; s++) begin
            if (bus.slot_valid[s]) begin
                need.push_back(fld(bus.slot_rs1, s));
                need.push_back(fld(bus.slot_rs2, s));
                need.push_back(fld(bus.slot_rd, s));
                if (bus.slot_long[s] && fld(bus.slot_rd, s) != 0) begin
                    if (long_dst.exists(fld(bus.slot_rd, s))) return 1'b1;
                    long_dst[fld(bus.slot_rd, s)] = 1;
                end
            end
        end
        foreach (need[i]) if (need[i] != 0 && m_busy[need[i]]) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every cycle on the falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin
        bit               hz, ok;
        int               gi, cnt;
        logic [N_REQ-1:0] g;
        if (!rst) model_reset();
        hz = model_hazard();
        ok = (bus.slot_valid != 0) && !hz && !bus.ext_stall;
        gi = -1;
        for (int k = 0; k < N_REQ; k++)
            if (gi < 0 && bus.cpl_req[(m_ptr + k) % N_REQ]) gi = (m_ptr + k) % N_REQ;
        g = '0;
        if (gi >= 0) g[gi] = 1'b1;
        cnt = 0;
        foreach (m_busy[r]) cnt += int'(m_busy[r]);

        check("hazard_stall", bus.hazard_stall, hz);
        check("issue_ok",     bus.issue_ok,     ok);
        check("cpl_gnt",      bus.cpl_gnt,      g);
        check("late_we",      bus.late_we,      m_we);
        check("late_rd",      bus.late_rd,      m_rd);
        check("late_data",    bus.late_data,    m_data);
        check("busy_cnt",     bus.busy_cnt,     cnt);

        if (rst) begin
            m_last_gnt = g;
            if (m_we) m_busy[m_rd] = 1'b0;
            if (ok)
                for (int s = 0; s < 4; s++)
                    if (bus.slot_valid[s] && bus.slot_long[s] && fld(bus.slot_rd, s) != 0)
                        m_busy[fld(bus.slot_rd, s)] = 1'b1;
            if (gi >= 0) begin
                m_we   = 1'b1;
                m_rd   = int'(bus.cpl_rd[gi*REG_W +: REG_W]);
                m_data = bus.cpl_data[gi*DATA_W +: DATA_W];
                m_ptr  = (gi + 1) % N_REQ;
            end else begin
                m_we = 1'b0;
            end
        end else begin
            m_last_gnt = '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        bus.ext_stall  = 1'b0;
        bus.slot_valid = '0;
        bus.slot_long  = '0;
        bus.slot_rd    = '0;
        bus.slot_rs1   = '0;
        bus.slot_rs2   = '0;
    endtask

    task automatic set_slot(input int s, input bit l, input int rd, input int rs1, input int rs2);
        bus.slot_valid[s]              = 1'b1;
        bus.slot_long[s]               = l;
        bus.slot_rd[s*REG_W +: REG_W]  = REG_W'(rd);
        bus.slot_rs1[s*REG_W +: REG_W] = REG_W'(rs1);
        bus.slot_rs2[s*REG_W +: REG_W] = REG_W'(rs2);
    endtask

    task automatic set_cpl(input int i, input bit req, input int rd, input logic [31:0] d);
        bus.cpl_req[i]                   = req;
        bus.cpl_rd[i*REG_W +: REG_W]     = REG_W'(rd);
        bus.cpl_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic random_cycle();
        int busy_list[$];
        int rd;
        for (int i = 0; i < N_REQ; i++) begin
            if (m_last_gnt[i]) begin
                bus.cpl_req[i] = 1'b0;
            end else if (!bus.cpl_req[i] && $urandom_range(0, 2) == 0) begin
                busy_list.delete();
                foreach (m_busy[r]) if (m_busy[r]) busy_list.push_back(r);
                if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                    rd = busy_list[$urandom_range(0, busy_list.size() - 1)];
                else
                    rd = $urandom_range(0, 15);
                set_cpl(i, 1'b1, rd, $urandom);
            end
        end
        clear_bundle();
        bus.ext_stall = ($urandom_range(0, 7) == 0);
        for (int s = 0; s < 4; s++) begin
            if ($urandom_range(0, 1) == 1)
                set_slot(s, $urandom_range(0, 2) == 0,
                         ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
                         ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
                         ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15));
        end
        // Legal decoders never pair two long ops on one destination
        for (int s = 1; s < 4; s++)
            for (int t = 0; t < s; t++)
                if (bus.slot_valid[s] && bus.slot_long[s] && bus.slot_valid[t] && bus.slot_long[t] &&
                    fld(bus.slot_rd, s) != 0 && fld(bus.slot_rd, s) == fld(bus.slot_rd, t))
                    bus.slot_long[s] = 1'b0;
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        clear_bundle();
        bus.cpl_req  = '0;
        bus.cpl_rd   = '0;
        bus.cpl_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Load to r10 at t0, dependent read stalls until completion at t5 clears it
        step(); set_slot(0, 1'b1, 10, 0, 0);
        @(negedge clk); check("t0 issue_ok", bus.issue_ok, 1'b1);
        step(); clear_bundle(); set_slot(0, 1'b0, 0, 10, 0);
        @(negedge clk); check("raw stall", bus.hazard_stall, 1'b1);
        check("cnt r10", bus.busy_cnt, 8'd1);
        repeat (3) step();
        step(); set_cpl(0, 1'b1, 10, 32'hCAFE_0010);
        @(negedge clk); check("t5 gnt", bus.cpl_gnt, 2'b01);
        step(); set_cpl(0, 1'b0, 0, 0);
        @(negedge clk); check("t6 late_we", bus.late_we, 1'b1);
        check("t6 late_rd", bus.late_rd, 7'd10);
        check("t6 late_data", bus.late_data, 32'hCAFE_0010);
        check("t6 still stall", bus.hazard_stall, 1'b1);
        step();
        @(negedge clk); check("t7 unstall", bus.hazard_stall, 1'b0);
        check("t7 issue_ok", bus.issue_ok, 1'b1);

        // WAW on r20, completed by unit 1 (pointer now at 1)
        step(); clear_bundle(); set_slot(1, 1'b1, 20, 0, 0);
        step(); clear_bundle(); set_slot(2, 1'b0, 20, 0, 0); set_slot(0, 1'b0, 0, 0, 0);
        @(negedge clk); check("waw stall", bus.hazard_stall, 1'b1);
        step(); set_cpl(1, 1'b1, 20, 32'h0000_0020);
        @(negedge clk); check("waw gnt", bus.cpl_gnt, 2'b10);
        step(); set_cpl(1, 1'b0, 0, 0);
        @(negedge clk); check("waw write cycle", bus.hazard_stall, 1'b1);
        step();
        @(negedge clk); check("waw clear", bus.hazard_stall, 1'b0);
        step(); clear_bundle(); set_slot(0, 1'b0, 0, 0, 0);
        @(negedge clk); check("r0 slot no stall", bus.issue_ok, 1'b1);

        // Round-robin fairness with both units requesting, then unit 1 alone
        step(); clear_bundle(); set_cpl(0, 1'b1, 0, 32'h1); set_cpl(1, 1'b1, 0, 32'h2);
        @(negedge clk); check("rr 0", bus.cpl_gnt, 2'b01);
        step(); @(negedge clk); check("rr 1", bus.cpl_gnt, 2'b10);
        step(); @(negedge clk); check("rr 2", bus.cpl_gnt, 2'b01);
        step(); @(negedge clk); check("rr 3", bus.cpl_gnt, 2'b10);
        step(); set_cpl(0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("rr solo", bus.cpl_gnt, 2'b10);
            step();
        end
        set_cpl(1, 1'b0, 0, 0);

        // Four long slots under ext_stall set nothing; released they set four bits
        for (int s = 0; s < 4; s++) set_slot(s, 1'b1, s + 1, 0, 0);
        bus.ext_stall = 1'b1;
        @(negedge clk); check("ext blocks issue", bus.issue_ok, 1'b0);
        step(); bus.ext_stall = 1'b0;
        @(negedge clk); check("ext no set", bus.busy_cnt, 8'd0);
        check("ext released", bus.issue_ok, 1'b1);
        step(); clear_bundle();
        @(negedge clk); check("four set", bus.busy_cnt, 8'd4);

        // Set of r5 and clear of r7 on the same edge (pointer now at 0)
        step(); set_slot(0, 1'b1, 7, 0, 0);
        step(); clear_bundle(); set_cpl(0, 1'b1, 7, 32'h7);
        @(negedge clk); check("cnt with r7", bus.busy_cnt, 8'd5);
        step(); set_cpl(0, 1'b0, 0, 0); set_slot(0, 1'b1, 5, 0, 0);
        @(negedge clk); check("r5 issue", bus.issue_ok, 1'b1);
        step(); clear_bundle(); set_slot(0, 1'b0, 0, 5, 0); set_cpl(1, 1'b1, 0, 32'h55);
        @(negedge clk); check("swap cnt", bus.busy_cnt, 8'd5);
        check("r5 busy", bus.hazard_stall, 1'b1);

        // Asynchronous reset mid-run with five busy registers and a live write port
        step(); set_cpl(1, 1'b0, 0, 0);
        @(negedge clk); check("pre-rst late_we", bus.late_we, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async busy_cnt", bus.busy_cnt, 8'd0);
        check("async late_we", bus.late_we, 1'b0);
        check("async hazard", bus.hazard_stall, 1'b0);
        step(); step(); rst = 1'b1;

        // Illegal duplicate long destination stalls indefinitely
        clear_bundle(); set_slot(0, 1'b1, 9, 0, 0); set_slot(3, 1'b1, 9, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("dup rd stall", bus.hazard_stall, 1'b1);
            step();
        end
        clear_bundle();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            random_cycle();
        end
        step(); clear_bundle(); bus.cpl_req = '0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
